seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 29 ++
 rtl/seg7_scan_driver.sv | 113 +++++++++++
 tb/tb_seg7_scan_driver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit 7-segment scan driver.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package seg7_pkg;

   localparam int DIGIT_W = 4;
   localparam int DIGIT_N = 4;

   typedef logic [DIGIT_W-1:0] digit_t;
   typedef logic [1:0]         idx_t;

   // Active-high segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high 7-segment pattern; non-decimal codes show a dash.
// Latency: combinational, zero cycles.
// Backpressure: none.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [6:0]         seg
);

   // Table lookup, dash for A..F
   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame digit snapshot.
// Latency: outputs registered from next-state cnt/idx/shadow; snapshot visible in the slot after the frame pulse.
// Backpressure: none, free-running scan. Optional SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV    = 50000,
   parameter int DEADTIME       = 500,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [DIGIT_W-1:0] Qdata3,
   input  logic [DIGIT_W-1:0] Qdata2,
   input  logic [DIGIT_W-1:0] Qdata1,
   input  logic [DIGIT_W-1:0] Qdata0,
   output logic [6:0]         seg,
   output logic [DIGIT_N-1:0] an,
   output logic               frame
);

   localparam int                 CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [6:0]         SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
   localparam logic [DIGIT_N-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [CNT_W-1:0]         cnt, cnt_nxt;
   idx_t                     idx, idx_nxt;
   digit_t [DIGIT_N-1:0]     shadow, shadow_nxt;
   logic                     tick;
   logic                     frame_nxt;
   logic                     in_dead;
   logic                     lz_blank;
   digit_t                   digit_sel;
   logic [6:0]               seg_dec;
   logic [6:0]               seg_ah;
   logic [DIGIT_N-1:0]       an_ah;
   logic [6:0]               seg_nxt;
   logic [DIGIT_N-1:0]       an_nxt;

   // Prescaler, slot index and end-of-frame snapshot
   always_comb begin
      tick       = (cnt == CNT_MAX);
      cnt_nxt    = tick ? '0 : cnt + CNT_W'(1);
      idx_nxt    = tick ? idx + 2'd1 : idx;
      frame_nxt  = tick && (idx == idx_t'(DIGIT_N - 1));
      shadow_nxt = frame_nxt ? {Qdata3, Qdata2, Qdata1, Qdata0} : shadow;
   end

   // Anode dead-time at the start of each slot; compiled away when zero
   if (DEADTIME == 0) begin : g_no_dead
      assign in_dead = 1'b0;
   end else begin : g_dead
      localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEADTIME);
      assign in_dead = (cnt_nxt < DEAD_END);
   end

`ifdef SEG7_LZB_EN
   // A digit is blank when it and every more significant digit are zero; units always shown
   always_comb begin
      lz_blank = 1'b0;
      case (idx_nxt)
         2'd3:    lz_blank = (shadow_nxt[3] == '0);
         2'd2:    lz_blank = (shadow_nxt[3] == '0) && (shadow_nxt[2] == '0);
         2'd1:    lz_blank = (shadow_nxt[3] == '0) && (shadow_nxt[2] == '0) && (shadow_nxt[1] == '0);
         default: lz_blank = 1'b0;
      endcase
   end
`else
   assign lz_blank = 1'b0;
`endif

   assign digit_sel = shadow_nxt[idx_nxt];

   seg7_decode u_decode (
      .digit (digit_sel),
      .seg   (seg_dec)
   );

   // Select active digit or blank, then apply output polarity last
   always_comb begin
      seg_ah = seg_dec;
      an_ah  = '0;
      if (in_dead || lz_blank) begin
         seg_ah = SEG_BLANK;
      end else begin
         an_ah[idx_nxt] = 1'b1;
      end
      seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
      an_nxt  = (AN_ACTIVE_LOW != 0)  ? ~an_ah  : an_ah;
   end

   // State and registered outputs; async reset returns to blank slot 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         idx    <= '0;
         shadow <= '0;
         frame  <= 1'b0;
         seg    <= SEG_OFF;
         an     <= AN_OFF;
      end else begin
         cnt    <= cnt_nxt;
         idx    <= idx_nxt;
         shadow <= shadow_nxt;
         frame  <= frame_nxt;
         seg    <= seg_nxt;
         an     <= an_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: REFRESH_DIV=8, DEADTIME=2 plus a DEADTIME=0 twin.
// Latency: expectations sampled on the falling edge, one slot = 8 cycles.
// Backpressure: n/a.
module tb_seg7_scan_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] q3, q2, q1, q0;
   logic [6:0] seg, seg_z;
   logic [3:0] an, an_z;
   logic       frame, frame_z;

   int checks = 0;
   int errors = 0;
   int k      = 0;

`ifdef SEG7_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .REFRESH_DIV(8), .DEADTIME(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst(rst),
      .Qdata3(q3), .Qdata2(q2), .Qdata1(q1), .Qdata0(q0),
      .seg(seg), .an(an), .frame(frame)
   );

   seg7_scan_driver #(
      .REFRESH_DIV(8), .DEADTIME(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut_z (
      .clk(clk), .rst(rst),
      .Qdata3(q3), .Qdata2(q2), .Qdata1(q1), .Qdata0(q0),
      .seg(seg_z), .an(an_z), .frame(frame_z)
   );

   // Checks cycles [c_first, c_last) of one slot, advancing one falling edge per cycle.
   task automatic run_slot(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg,
                           input logic exp_frame, input int c_first, input int c_last);
      for (int c = c_first; c < c_last; c++) begin
         logic [3:0] ea;
         logic [6:0] es;
         logic       ef;
         ea = (c < 2) ? 4'hF  : exp_an;
         es = (c < 2) ? 7'h7F : exp_seg;
         ef = (c == 0) ? exp_frame : 1'b0;
         checks++;
         assert (an === ea) else begin
            errors++; $error("FAIL %s c=%0d an obs=%b exp=%b", tag, c, an, ea);
         end
         checks++;
         assert (seg === es) else begin
            errors++; $error("FAIL %s c=%0d seg obs=%h exp=%h", tag, c, seg, es);
         end
         checks++;
         assert (frame === ef) else begin
            errors++; $error("FAIL %s c=%0d frame obs=%b exp=%b", tag, c, frame, ef);
         end
         if (k != 0) begin
            checks++;
            assert (an_z === exp_an) else begin
               errors++; $error("FAIL %s_dt0 c=%0d an obs=%b exp=%b", tag, c, an_z, exp_an);
            end
            checks++;
            assert (seg_z === exp_seg) else begin
               errors++; $error("FAIL %s_dt0 c=%0d seg obs=%h exp=%h", tag, c, seg_z, exp_seg);
            end
            checks++;
            assert (frame_z === ef) else begin
               errors++; $error("FAIL %s_dt0 c=%0d frame obs=%b exp=%b", tag, c, frame_z, ef);
            end
         end
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      rst = 1'b0;
      q3 = 4'd9; q2 = 4'd6; q1 = 4'd7; q0 = 4'd5;
      @(negedge clk);
      @(negedge clk);

      // Reset state
      checks++;
      assert (an === 4'hF) else begin errors++; $error("FAIL rst_an obs=%b exp=1111", an); end
      checks++;
      assert (seg === 7'h7F) else begin errors++; $error("FAIL rst_seg obs=%h exp=7f", seg); end
      checks++;
      assert (frame === 1'b0) else begin errors++; $error("FAIL rst_frame obs=%b exp=0", frame); end
      checks++;
      assert (an_z === 4'hF) else begin errors++; $error("FAIL rst_an_dt0 obs=%b exp=1111", an_z); end

      rst = 1'b1;
      k   = 0;

      // Frame 1: shadow still zero
      run_slot("f1s0", 4'b1110, 7'h40, 1'b0, 0, 8);
      run_slot("f1s1", LZB ? 4'hF : 4'b1101, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);
      run_slot("f1s2", LZB ? 4'hF : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);
      run_slot("f1s3", LZB ? 4'hF : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);

      // Frame 2: 9675
      run_slot("f2s0", 4'b1110, 7'h12, 1'b1, 0, 8);
      run_slot("f2s1", 4'b1101, 7'h78, 1'b0, 0, 8);
      run_slot("f2s2", 4'b1011, 7'h02, 1'b0, 0, 8);
      run_slot("f2s3", 4'b0111, 7'h10, 1'b0, 0, 8);

      // Frame 3: inputs change mid-frame, display keeps the old snapshot
      run_slot("f3s0a", 4'b1110, 7'h12, 1'b1, 0, 3);
      q0 = 4'd3;
      q1 = 4'hC;
      run_slot("f3s0b", 4'b1110, 7'h12, 1'b0, 3, 8);
      run_slot("f3s1", 4'b1101, 7'h78, 1'b0, 0, 8);
      run_slot("f3s2", 4'b1011, 7'h02, 1'b0, 0, 8);
      run_slot("f3s3", 4'b0111, 7'h10, 1'b0, 0, 8);

      // Frame 4: 9 6 dash 3
      run_slot("f4s0", 4'b1110, 7'h30, 1'b1, 0, 8);
      q3 = 4'd0; q2 = 4'd0; q1 = 4'd4; q0 = 4'd2;
      run_slot("f4s1", 4'b1101, 7'h3F, 1'b0, 0, 8);
      run_slot("f4s2", 4'b1011, 7'h02, 1'b0, 0, 8);
      run_slot("f4s3", 4'b0111, 7'h10, 1'b0, 0, 8);

      // Frame 5: 0042
      run_slot("f5s0", 4'b1110, 7'h24, 1'b1, 0, 8);
      q1 = 4'd0; q0 = 4'd0;
      run_slot("f5s1", 4'b1101, 7'h19, 1'b0, 0, 8);
      run_slot("f5s2", LZB ? 4'hF : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);
      run_slot("f5s3", LZB ? 4'hF : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);

      // Frame 6: 0000
      run_slot("f6s0", 4'b1110, 7'h40, 1'b1, 0, 8);
      run_slot("f6s1", LZB ? 4'hF : 4'b1101, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);
      run_slot("f6s2", LZB ? 4'hF : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);
      run_slot("f6s3", LZB ? 4'hF : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);

      // Frame 7: reset asserted at cnt=5 of slot 2
      run_slot("f7s0", 4'b1110, 7'h40, 1'b1, 0, 8);
      q3 = 4'd1; q2 = 4'd2; q1 = 4'd3; q0 = 4'd8;
      run_slot("f7s1", LZB ? 4'hF : 4'b1101, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);
      run_slot("f7s2", LZB ? 4'hF : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b0, 0, 5);
      rst = 1'b0;
      #1;
      checks++;
      assert (an === 4'hF) else begin errors++; $error("FAIL midrst_an obs=%b exp=1111", an); end
      checks++;
      assert (seg === 7'h7F) else begin errors++; $error("FAIL midrst_seg obs=%h exp=7f", seg); end
      checks++;
      assert (frame === 1'b0) else begin errors++; $error("FAIL midrst_frame obs=%b exp=0", frame); end
      checks++;
      assert (an_z === 4'hF) else begin errors++; $error("FAIL midrst_an_dt0 obs=%b exp=1111", an_z); end
      @(negedge clk);
      rst = 1'b1;
      k   = 0;

      // Restart at slot 0 with cleared snapshot, then 1238 appears next frame
      run_slot("r0s0", 4'b1110, 7'h40, 1'b0, 0, 8);
      run_slot("r0s1", LZB ? 4'hF : 4'b1101, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);
      run_slot("r0s2", LZB ? 4'hF : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);
      run_slot("r0s3", LZB ? 4'hF : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b0, 0, 8);
      run_slot("r1s0", 4'b1110, 7'h00, 1'b1, 0, 8);
      run_slot("r1s1", 4'b1101, 7'h30, 1'b0, 0, 8);
      run_slot("r1s2", 4'b1011, 7'h24, 1'b0, 0, 8);
      run_slot("r1s3", 4'b0111, 7'h79, 1'b0, 0, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
